// File: rtl/fp16_divider.sv
// fp16_divider: sequential fp16 divider, restoring mantissa division one quotient bit per cycle
module fp16_divider #(
  parameter int EXP_BIAS = 15,
  parameter int QBITS    = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din_a,
  input  logic [15:0] din_b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] dout,
  output logic        out_valid,
  input  logic        out_ready
);
  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;
  state_t state, state_nx;
  logic              sign;
  logic [4:0]        ea, eb;
  logic [10:0]       mb;
  logic [11:0]       rem, rem_sub, q;
  logic [3:0]        cnt;
  logic              ge;
  logic signed [6:0] e;
  logic [15:0]       norm_val, spec_val;
  logic              spec, s_in;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  // operand classification and special-case results, resolved at accept
  always_comb begin
    a_zero   = din_a[14:10] == 5'd0;
    b_zero   = din_b[14:10] == 5'd0;
    a_inf    = din_a[14:10] == 5'h1F && din_a[9:0] == 10'd0;
    b_inf    = din_b[14:10] == 5'h1F && din_b[9:0] == 10'd0;
    a_nan    = din_a[14:10] == 5'h1F && din_a[9:0] != 10'd0;
    b_nan    = din_b[14:10] == 5'h1F && din_b[9:0] != 10'd0;
    s_in     = din_a[15] ^ din_b[15];
    spec     = a_zero || b_zero || a_inf || b_inf || a_nan || b_nan;
    spec_val = (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) ? 16'h7E00 :
               (a_inf || b_zero) ? {s_in, 5'h1F, 10'h0} : {s_in, 15'h0};
  end
  // one restoring step plus exponent/normalisation of the finished quotient
  always_comb begin
    ge       = rem >= {1'b0, mb};
    rem_sub  = ge ? rem - {1'b0, mb} : rem;
    e        = 7'(ea) - 7'(eb) + 7'(EXP_BIAS) - (q[11] ? 7'sd0 : 7'sd1);
    norm_val = e >= 7'sd31 ? {sign, 5'h1F, 10'h0} :
               e <= 7'sd0  ? {sign, 15'h0} :
               {sign, e[4:0], q[11] ? q[10:1] : q[9:0]};
  end
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // next-state logic
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (in_valid ? (spec ? DONE : DIV) : IDLE) :
               state == DIV  ? (cnt == 4'(QBITS - 1) ? NORM : DIV) :
               state == NORM ? DONE :
               (out_ready ? IDLE : DONE);
  end
  // datapath: capture operands, shift in quotient bits, produce result
  always_ff @(posedge clk) begin
    if (rst) begin
      sign <= 1'b0;
      ea   <= '0;
      eb   <= '0;
      mb   <= '0;
      rem  <= '0;
      q    <= '0;
      cnt  <= '0;
      dout <= '0;
    end else if (state == IDLE && in_valid) begin
      sign <= s_in;
      ea   <= din_a[14:10];
      eb   <= din_b[14:10];
      mb   <= {1'b1, din_b[9:0]};
      rem  <= {2'b01, din_a[9:0]};
      q    <= '0;
      cnt  <= '0;
      if (spec) dout <= spec_val;
    end else if (state == DIV) begin
      q    <= {q[10:0], ge};
      rem  <= {rem_sub[10:0], 1'b0};
      cnt  <= cnt + 4'd1;
    end else if (state == NORM) begin
      dout <= norm_val;
    end
  end
endmodule
